// File: rtl/sram_bist_pkg.sv
// Shared constants for the two-port SRAM March C- BIST: FSM encoding and the
// per-element march table (direction, read/write presence, backgrounds).
package sram_bist_pkg;

  localparam int NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Operations of one march element; a two-op element issues read then write.
  typedef struct packed {
    logic has_rd;
    logic has_wr;
    logic rd_bg;
    logic wr_bg;
  } march_ops_t;

  function automatic march_ops_t elem_ops(input logic [2:0] e);
    march_ops_t o;
    case (e)
      3'd0:    o = '{has_rd: 1'b0, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0};
      3'd1:    o = '{has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      3'd2:    o = '{has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      3'd3:    o = '{has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      3'd4:    o = '{has_rd: 1'b1, has_wr: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      3'd5:    o = '{has_rd: 1'b1, has_wr: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic elem_is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

endpackage

// File: rtl/march_addr_seq.sv
// Up/down address counter for march elements: load sets the direction and the
// start address, step moves one word, at_term flags the element's last address.
module march_addr_seq #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  at_term
);

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  logic down;

  always_ff @(posedge clk) begin
    if (reset) begin
      down <= 1'b0;
      addr <= '0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - ONE : addr + ONE;
    end
  end

  assign at_term = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_2p_march_bist.sv
// March C- BIST controller for a two-port SRAM with registered read data:
// runs the march on port A, optionally repeats on port B, records first failure.
module sram_2p_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH  = 20,
  parameter int ADDR_WIDTH  = 9,
  parameter int TEST_PORT_B = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  bist_active,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  fail_port,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic                  a_men,
  output logic                  a_wen,
  output logic                  a_ren,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_din,
  input  logic [DATA_WIDTH-1:0] a_dout,
  output logic                  b_men,
  output logic                  b_wen,
  output logic                  b_ren,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_din,
  input  logic [DATA_WIDTH-1:0] b_dout
);

  localparam logic DO_PORT_B = (TEST_PORT_B != 0);

  logic [1:0]            state;
  logic                  port_b;
  logic [2:0]            elem;
  logic                  phase;
  march_ops_t            ops;
  logic                  running, start_ok, go_b;
  logic                  op_rd, op_wr, last_op;
  logic                  seq_load, seq_load_down, seq_step, at_term;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [DATA_WIDTH-1:0] wr_data, dout_sel;
  logic                  mismatch;

  // Tags of the read issued last cycle, compared against this cycle's dout.
  logic                  rd_vld, rd_port;
  logic [2:0]            rd_elem;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_exp;

  assign ops      = elem_ops(elem);
  assign running  = (state == ST_RUN);
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign go_b     = DO_PORT_B && !port_b;
  assign op_rd    = ops.has_rd && (!ops.has_wr || !phase);
  assign op_wr    = ops.has_wr && (!ops.has_rd || phase);
  assign last_op  = !(ops.has_rd && ops.has_wr) || phase;
  assign wr_data  = {DATA_WIDTH{ops.wr_bg}};
  assign dout_sel = rd_port ? b_dout : a_dout;
  assign mismatch = rd_vld && (dout_sel != rd_exp);

  always_comb begin
    seq_load      = 1'b0;
    seq_load_down = 1'b0;
    seq_step      = 1'b0;
    if (start_ok) begin
      seq_load = 1'b1;
    end else if (running && !mismatch && last_op) begin
      if (!at_term) begin
        seq_step = 1'b1;
      end else if (elem != LAST_ELEM) begin
        seq_load      = 1'b1;
        seq_load_down = elem_is_down(elem + 3'd1);
      end else if (go_b) begin
        seq_load = 1'b1;
      end
    end
  end

  march_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_seq (
    .clk       (clk),
    .reset     (reset),
    .load      (seq_load),
    .load_down (seq_load_down),
    .step      (seq_step),
    .addr      (seq_addr),
    .at_term   (at_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      port_b        <= 1'b0;
      elem          <= '0;
      phase         <= 1'b0;
      rd_vld        <= 1'b0;
      rd_port       <= 1'b0;
      rd_elem       <= '0;
      rd_addr       <= '0;
      rd_exp        <= '0;
      fail          <= 1'b0;
      fail_port     <= 1'b0;
      fail_elem     <= '0;
      fail_addr     <= '0;
      fail_syndrome <= '0;
    end else begin
      rd_vld  <= running && op_rd && !mismatch;
      rd_port <= port_b;
      rd_elem <= elem;
      rd_addr <= seq_addr;
      rd_exp  <= {DATA_WIDTH{ops.rd_bg}};
      if (mismatch) begin
        fail          <= 1'b1;
        fail_port     <= rd_port;
        fail_elem     <= rd_elem;
        fail_addr     <= rd_addr;
        fail_syndrome <= rd_exp ^ dout_sel;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_RUN;
            port_b        <= 1'b0;
            elem          <= '0;
            phase         <= 1'b0;
            fail          <= 1'b0;
            fail_port     <= 1'b0;
            fail_elem     <= '0;
            fail_addr     <= '0;
            fail_syndrome <= '0;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            state <= ST_DONE;
          end else begin
            phase <= (ops.has_rd && ops.has_wr) ? !phase : 1'b0;
            if (last_op && at_term) begin
              if (elem != LAST_ELEM) begin
                elem <= elem + 3'd1;
              end else if (go_b) begin
                port_b <= 1'b1;
                elem   <= '0;
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign bist_active = busy;
  assign done        = (state == ST_DONE);

  assign a_men  = running && !port_b;
  assign a_wen  = a_men && op_wr;
  assign a_ren  = a_men && op_rd;
  assign a_addr = a_men ? seq_addr : '0;
  assign a_din  = a_wen ? wr_data : '0;
  assign b_men  = running && port_b;
  assign b_wen  = b_men && op_wr;
  assign b_ren  = b_men && op_rd;
  assign b_addr = b_men ? seq_addr : '0;
  assign b_din  = b_wen ? wr_data : '0;

endmodule
